// File: rtl/comparador_serial_izq_der_pkg.sv
// Package comparador_pkg
// Shared types for the bit-serial MSB-first comparator:
//   estado_t : FSM states (IDLE, COMPARE, DONE)
//   rel_t    : running relation between the scanned prefixes of A and B
//   rel_a_zout() : maps a final relation onto the Zout convention (A <= B)
package comparador_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COMPARE = 2'b01,
        DONE    = 2'b10
    } estado_t;

    typedef enum logic [1:0] {
        REL_EQ    = 2'b00,
        REL_MENOR = 2'b01,
        REL_MAYOR = 2'b10
    } rel_t;

    // Zout is 1 unless A was found strictly greater than B
    function automatic logic rel_a_zout(input rel_t rel);
        return (rel != REL_MAYOR) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/comparador_serial_izq_der_celda.sv
// Module celda_comparadora
// One cell of the iterative comparator network, evaluated MSB first.
// Once the relation has been decided by a more significant bit it is
// passed through unchanged; otherwise the current bit pair decides it.
// Ports:
//   a_i, b_i : current bit of A and B
//   rel_in   : relation decided by the more significant bits
//   rel_out  : relation including the current bit
module celda_comparadora
    import comparador_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  rel_t rel_in,
    output rel_t rel_out
);

    // Relation update for one bit pair
    always_comb begin
        rel_out = rel_in;
        if (rel_in == REL_EQ) begin
            if (a_i && !b_i) begin
                rel_out = REL_MAYOR;
            end else if (!a_i && b_i) begin
                rel_out = REL_MENOR;
            end else begin
                rel_out = REL_EQ;
            end
        end else begin
            rel_out = rel_in;
        end
    end

endmodule

// File: rtl/comparador_serial_izq_der.sv
// Module comparador_serial_izq_der
// Bit-serial comparator scanning A and B from MSB to LSB, one bit pair per
// clock, using a single reused celda_comparadora.  Zout = 1 iff A <= B.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   start : sample A/B and begin a compare (ignored while busy)
//   A, B  : N-bit operands, only sampled with start
//   busy  : high while comparing
//   done  : one-cycle pulse, Zout updated in the same cycle
//   Zout  : last result (A <= B), held until the next done
// Build option: define COMPARADOR_SALIDA_TEMPRANA_EN to leave COMPARE as
// soon as the relation is decided (variable latency); undefined gives a
// fixed latency of N+1 cycles.  Zout is the same in both builds.
module comparador_serial_izq_der
    import comparador_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic         Zout
);

    localparam int CNT_W = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] IDX_INI = CNT_W'(N - 1);

    estado_t          state_q, state_d;
    rel_t             rel_q, rel_d;
    rel_t             rel_celda_s;
    logic [N-1:0]     sh_a_q, sh_a_d;
    logic [N-1:0]     sh_b_q, sh_b_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             zout_q, zout_d;
    logic             fin_s;

    celda_comparadora u_celda (
        .a_i     (sh_a_q[N-1]),
        .b_i     (sh_b_q[N-1]),
        .rel_in  (rel_q),
        .rel_out (rel_celda_s)
    );

    // Last scanned bit, or (early-exit build) relation already decided
    always_comb begin
`ifdef COMPARADOR_SALIDA_TEMPRANA_EN
        fin_s = (idx_q == CNT_W'(0)) || (rel_celda_s != REL_EQ);
`else
        fin_s = (idx_q == CNT_W'(0));
`endif
    end

    // Next-state, datapath and output computation
    always_comb begin
        state_d = state_q;
        rel_d   = rel_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        idx_d   = idx_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        zout_d  = zout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sh_a_d  = A;
                    sh_b_d  = B;
                    rel_d   = REL_EQ;
                    idx_d   = IDX_INI;
                    busy_d  = 1'b1;
                    state_d = COMPARE;
                end else begin
                    state_d = IDLE;
                end
            end
            COMPARE: begin
                rel_d  = rel_celda_s;
                sh_a_d = sh_a_q << 1'b1;
                sh_b_d = sh_b_q << 1'b1;
                idx_d  = idx_q - CNT_W'(1);
                if (fin_s) begin
                    done_d  = 1'b1;
                    zout_d  = rel_a_zout(rel_celda_s);
                    state_d = DONE;
                end else begin
                    busy_d  = 1'b1;
                    state_d = COMPARE;
                end
            end
            DONE: begin
                // A start here restarts immediately, with no IDLE cycle
                if (start) begin
                    sh_a_d  = A;
                    sh_b_d  = B;
                    rel_d   = REL_EQ;
                    idx_d   = IDX_INI;
                    busy_d  = 1'b1;
                    state_d = COMPARE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rel_q   <= REL_EQ;
            sh_a_q  <= {N{1'b0}};
            sh_b_q  <= {N{1'b0}};
            idx_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rel_q   <= rel_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            zout_q  <= zout_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Zout = zout_q;

endmodule
